// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES core: paces the key-expansion engine
// and the round datapath through rounds 0..NUM_ROUNDS with stall timeouts.
module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int TIMEOUT    = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    output logic       kx_enable,
    output logic       kx_ack,
    input  logic       kx_ready,
    input  logic [3:0] kx_round,
    output logic       dp_load,
    output logic       dp_round_en,
    output logic       dp_last,
    output logic [3:0] dp_round_idx,
    input  logic       dp_valid,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
    localparam logic [3:0]     LAST_RND  = 4'(NUM_ROUNDS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KWAIT = 3'd1,
        ISSUE = 3'd2,
        DWAIT = 3'd3,
        ACK   = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [3:0]     r_round_cnt;
    logic [WCW-1:0] r_wait_cnt;

    logic r_kx_enable, r_kx_ack, r_dp_load, r_dp_round_en, r_dp_last;
    logic r_busy, r_done, r_err;
    logic w_kx_enable, w_kx_ack, w_dp_load, w_dp_round_en, w_dp_last;
    logic w_busy, w_done, w_err;
    logic w_wait_exp;

    assign w_wait_exp = (r_wait_cnt == WAIT_LAST);

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:  if (start) w_next = KWAIT;
                KWAIT: begin
                    if (kx_ready)
                        w_next = (kx_round == r_round_cnt) ? ISSUE : ERR;
                    else if (w_wait_exp)
                        w_next = ERR;
                end
                ISSUE: w_next = DWAIT;
                DWAIT: begin
                    if (dp_valid)
                        w_next = (r_round_cnt == LAST_RND) ? DONE : ACK;
                    else if (w_wait_exp)
                        w_next = ERR;
                end
                ACK:   w_next = KWAIT;
                DONE:  w_next = IDLE;
                ERR:   w_next = ERR;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_round_cnt <= 4'd0;
            r_wait_cnt  <= '0;
        end else begin
            r_state <= w_next;
            if (!abort && r_state == IDLE && start)
                r_round_cnt <= 4'd0;
            else if (!abort && r_state == ACK)
                r_round_cnt <= r_round_cnt + 4'd1;
            // Counter restarts on every entry into a wait state.
            if ((r_state == KWAIT || r_state == DWAIT) && w_next == r_state)
                r_wait_cnt <= r_wait_cnt + WCW'(1);
            else
                r_wait_cnt <= '0;
        end
    end

    always_comb begin
        w_kx_enable   = (r_state != IDLE) && (r_state != ERR);
        w_kx_ack      = (r_state == ACK) || (r_state == DONE);
        w_dp_load     = (r_state == ISSUE) && (r_round_cnt == 4'd0);
        w_dp_round_en = (r_state == ISSUE) && (r_round_cnt != 4'd0);
        w_dp_last     = (r_state == ISSUE) && (r_round_cnt == LAST_RND);
        w_busy        = (r_state != IDLE);
        w_done        = (r_state == DONE);
        w_err         = (r_state == ERR);
    end

    // Outputs are a registered decode of the state, one cycle behind it;
    // abort squashes them so nothing leaks out on the abort edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_kx_enable   <= 1'b0;
            r_kx_ack      <= 1'b0;
            r_dp_load     <= 1'b0;
            r_dp_round_en <= 1'b0;
            r_dp_last     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_kx_enable   <= w_kx_enable   & ~abort;
            r_kx_ack      <= w_kx_ack      & ~abort;
            r_dp_load     <= w_dp_load     & ~abort;
            r_dp_round_en <= w_dp_round_en & ~abort;
            r_dp_last     <= w_dp_last     & ~abort;
            r_busy        <= w_busy        & ~abort;
            r_done        <= w_done        & ~abort;
            r_err         <= w_err         & ~abort;
        end
    end

    assign kx_enable    = r_kx_enable;
    assign kx_ack       = r_kx_ack;
    assign dp_load      = r_dp_load;
    assign dp_round_en  = r_dp_round_en;
    assign dp_last      = r_dp_last;
    assign dp_round_idx = r_round_cnt;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: a small engine/datapath responder
// drives the handshakes while each scenario task checks its own results.
module tb_aes_round_ctrl;

    localparam int NR = 10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       kx_ready = 1'b0;
    logic [3:0] kx_round = 4'd0;
    logic       dp_valid = 1'b0;
    logic       kx_enable, kx_ack, dp_load, dp_round_en, dp_last, busy, done, err;
    logic [3:0] dp_round_idx;

    int checks = 0;
    int errors = 0;

    aes_round_ctrl #(.NUM_ROUNDS(NR), .TIMEOUT(64)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .kx_enable(kx_enable), .kx_ack(kx_ack), .kx_ready(kx_ready),
        .kx_round(kx_round), .dp_load(dp_load), .dp_round_en(dp_round_en),
        .dp_last(dp_last), .dp_round_idx(dp_round_idx), .dp_valid(dp_valid),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] outs();
        return {kx_enable, kx_ack, dp_load, dp_round_en, dp_last, dp_round_idx, busy, done, err};
    endfunction

    // Runs one block from a start pulse; -1 disables each optional disturbance.
    task automatic run_block(input int kst_n, input int dst_round, input int dst_n,
                             input int mis_round, input int abort_round, input int rst_round,
                             input int glitch_cyc,
                             output int n_load, output int n_ren, output int n_last,
                             output int n_last_bad, output int n_ack, output int done_cyc,
                             output int err_cyc, output logic [12:0] rst_outs);
        int cyc, kst_used, dv_wait, stop_cyc;
        logic pulse;
        n_load = 0; n_ren = 0; n_last = 0; n_last_bad = 0; n_ack = 0;
        done_cyc = -1; err_cyc = -1; rst_outs = '1;
        kst_used = 0; dv_wait = -1; stop_cyc = -1;
        kx_ready = 1'b1; dp_valid = 1'b0; abort = 1'b0; kx_round = 4'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 200 && !(stop_cyc >= 0 && cyc >= stop_cyc)) begin
            if (dp_load) n_load++;
            if (dp_round_en) n_ren++;
            if (dp_last) begin
                if (dp_round_en && dp_round_idx == 4'(NR)) n_last++;
                else n_last_bad++;
            end
            if (kx_ack) n_ack++;
            if (done && done_cyc < 0) begin
                done_cyc = cyc;
                stop_cyc = cyc + 1;
            end
            if (err) begin
                err_cyc = cyc;
                break;
            end
            pulse = dp_load | dp_round_en;
            abort = 1'b0;
            kx_round = (int'(dp_round_idx) == mis_round) ? dp_round_idx + 4'd1 : dp_round_idx;
            kx_ready = !(dp_round_idx == 4'd3 && kst_used < kst_n);
            if (!kx_ready) kst_used++;
            if (pulse) dv_wait = (int'(dp_round_idx) == dst_round) ? dst_n : 0;
            if (dv_wait == 0) begin
                dp_valid = 1'b1;
                dv_wait = -1;
            end else begin
                dp_valid = 1'b0;
                if (dv_wait > 0) dv_wait--;
            end
            if (pulse && int'(dp_round_idx) == abort_round) begin
                abort = 1'b1;
                stop_cyc = cyc + 4;
            end
            if (pulse && int'(dp_round_idx) == rst_round) begin
                reset_n = 1'b0;
                #1;
                rst_outs = outs();
                @(posedge clk); #1;
                reset_n = 1'b1;
                break;
            end
            start = (cyc == glitch_cyc);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; abort = 1'b0; dp_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (outs() !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0000", outs());
        end
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (outs() !== 13'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h expected 0000", outs());
        end
    endtask

    task automatic test_nominal();
        int nl, nr, nla, nlb, na, dc, ec;
        logic [12:0] ro;
        run_block(0, -1, 0, -1, -1, -1, -1, nl, nr, nla, nlb, na, dc, ec, ro);
        checks++; if (nl !== 1)  begin errors++; $display("FAIL nom_load: got %0d expected 1", nl); end
        checks++; if (nr !== 10) begin errors++; $display("FAIL nom_round_en: got %0d expected 10", nr); end
        checks++; if (nla !== 1 || nlb !== 0) begin errors++; $display("FAIL nom_last: got %0d/%0d expected 1/0", nla, nlb); end
        checks++; if (na !== 11) begin errors++; $display("FAIL nom_kx_ack: got %0d expected 11", na); end
        checks++; if (dc !== 44) begin errors++; $display("FAIL nom_done_cycle: got %0d expected 44", dc); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL nom_idle_after: busy %b done %b expected 0 0", busy, done); end
    endtask

    task automatic test_stalls();
        int nl, nr, nla, nlb, na, dc, ec;
        logic [12:0] ro;
        run_block(5, 7, 7, -1, -1, -1, -1, nl, nr, nla, nlb, na, dc, ec, ro);
        checks++; if (nl !== 1 || nr !== 10) begin errors++; $display("FAIL stall_pulses: got %0d/%0d expected 1/10", nl, nr); end
        checks++; if (na !== 11) begin errors++; $display("FAIL stall_kx_ack: got %0d expected 11", na); end
        checks++; if (dc !== 56) begin errors++; $display("FAIL stall_done_cycle: got %0d expected 56", dc); end
    endtask

    task automatic test_mismatch();
        int nl, nr, nla, nlb, na, dc, ec;
        logic [12:0] ro;
        run_block(0, -1, 0, 4, -1, -1, -1, nl, nr, nla, nlb, na, dc, ec, ro);
        checks++; if (ec !== 18) begin errors++; $display("FAIL mis_err_cycle: got %0d expected 18", ec); end
        checks++; if (kx_enable !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL mis_err_outputs: kx_enable %b busy %b expected 0 1", kx_enable, busy); end
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (err !== 1'b1 || dc !== -1) begin errors++; $display("FAIL mis_err_sticky: err %b done_cyc %0d expected 1 -1", err, dc); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mis_abort_clear: err %b busy %b expected 0 0", err, busy); end
    endtask

    task automatic test_timeout();
        int nl, nr, nla, nlb, na, dc, ec;
        logic [12:0] ro;
        run_block(0, 2, 1000, -1, -1, -1, -1, nl, nr, nla, nlb, na, dc, ec, ro);
        checks++; if (ec !== 75) begin errors++; $display("FAIL tmo_err_cycle: got %0d expected 75", ec); end
        checks++; if (na !== 2 || nr !== 2) begin errors++; $display("FAIL tmo_progress: ack %0d ren %0d expected 2 2", na, nr); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_abort: err %b expected 0", err); end
    endtask

    task automatic test_collisions();
        int nl, nr, nla, nlb, na, dc, ec;
        logic [12:0] ro;
        run_block(0, -1, 0, -1, 10, -1, -1, nl, nr, nla, nlb, na, dc, ec, ro);
        checks++; if (dc !== -1) begin errors++; $display("FAIL col_abort_no_done: done_cyc %0d expected -1", dc); end
        checks++; if (na !== 10 || busy !== 1'b0) begin errors++; $display("FAIL col_abort_state: ack %0d busy %b expected 10 0", na, busy); end
        run_block(0, -1, 0, -1, -1, -1, 20, nl, nr, nla, nlb, na, dc, ec, ro);
        checks++; if (dc !== 44 || nl !== 1) begin errors++; $display("FAIL col_start_busy: done_cyc %0d load %0d expected 44 1", dc, nl); end
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL col_abort_over_start: busy %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int nl, nr, nla, nlb, na, dc, ec;
        logic [12:0] ro;
        run_block(0, -1, 0, -1, -1, 6, -1, nl, nr, nla, nlb, na, dc, ec, ro);
        checks++; if (ro !== 13'd0) begin errors++; $display("FAIL rst_mid_outputs: got %h expected 0000", ro); end
        checks++; if (dc !== -1) begin errors++; $display("FAIL rst_mid_no_done: done_cyc %0d expected -1", dc); end
        run_block(0, -1, 0, -1, -1, -1, -1, nl, nr, nla, nlb, na, dc, ec, ro);
        checks++; if (dc !== 44 || nr !== 10 || na !== 11) begin errors++; $display("FAIL rst_mid_rerun: done %0d ren %0d ack %0d expected 44 10 11", dc, nr, na); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stalls();
        test_mismatch();
        test_timeout();
        test_collisions();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
